adc_moving_averager: RTL and testbench

- Sliding-window (boxcar) moving average over the last 2^DEPTH_LOG2 XADC conversions.
- Sits between the XADC DRP read-out and adc_scaling; its averaged_adc output feeds adc_scaling directly.
- Accepts one 16-bit left-justified sample per strobe and emits one averaged word per accepted sample once the window is full.

---
 rtl/adc_pkg.sv | 9 +
 rtl/adc_sample_ring.sv | 35 +++
 rtl/adc_moving_averager.sv | 86 ++++++++
 tb/tb_adc_moving_averager.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC word type and moving-average default sizing
package adc_pkg;

   localparam int ADC_DATA_W     = 16;
   localparam int AVG_DEPTH_LOG2 = 4;

   typedef logic [ADC_DATA_W-1:0] adc_word_t;

endpackage

// File: rtl/adc_sample_ring.sv
// rtl/adc_sample_ring.sv - sample ring RAM with write pointer and async read of the oldest word
module adc_sample_ring
   import adc_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int DEPTH_LOG2 = AVG_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (reset || clear)
         wr_ptr <= '0;
      else if (wr_en)
         wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
   end

   // Contents are deliberately not reset; the averager masks stale words during warm-up.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/adc_moving_averager.sv
// rtl/adc_moving_averager.sv - boxcar average over the last 2^DEPTH_LOG2 samples
// ADC_AVG_ROUND_EN: round-half-up with saturation instead of floor.
module adc_moving_averager
   import adc_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int DEPTH_LOG2 = AVG_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              flush,
   output logic [DATA_W-1:0] averaged_adc,
   output logic              avg_valid,
   output logic              window_full
);
   localparam int                  SUM_W    = DATA_W + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

   logic [SUM_W-1:0]    sum;
   logic [DEPTH_LOG2:0] fill_cnt;
   logic [DEPTH_LOG2:0] fill_next;
   logic                full_next;
   logic                s1_valid;
   logic                accept;
   logic [DATA_W-1:0]   oldest;
   logic [DATA_W-1:0]   evicted;
   logic [DATA_W-1:0]   avg_calc;

   assign accept    = sample_valid && !flush && !reset;
   assign fill_next = (fill_cnt == FULL_CNT) ? fill_cnt : fill_cnt + (DEPTH_LOG2 + 1)'(1);
   assign full_next = (fill_next == FULL_CNT);
   // Until the window is full the slot at wr_ptr holds garbage, so subtract zero instead.
   assign evicted   = window_full ? oldest : '0;

   adc_sample_ring #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .wr_en   (accept),
      .wr_data (sample_data),
      .rd_data (oldest)
   );

`ifdef ADC_AVG_ROUND_EN
   localparam logic [SUM_W:0] HALF = (SUM_W + 1)'(1) << (DEPTH_LOG2 - 1);
   logic [DATA_W:0] quot;
   assign quot     = (DATA_W + 1)'(({1'b0, sum} + HALF) >> DEPTH_LOG2);
   assign avg_calc = quot[DATA_W] ? '1 : quot[DATA_W-1:0];
`else
   assign avg_calc = DATA_W'(sum >> DEPTH_LOG2);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sum          <= '0;
         fill_cnt     <= '0;
         window_full  <= 1'b0;
         s1_valid     <= 1'b0;
         avg_valid    <= 1'b0;
         averaged_adc <= '0;
      end else if (flush) begin
         sum         <= '0;
         fill_cnt    <= '0;
         window_full <= 1'b0;
         s1_valid    <= 1'b0;
         avg_valid   <= 1'b0;
      end else begin
         s1_valid  <= accept && full_next;
         avg_valid <= s1_valid;
         if (s1_valid)
            averaged_adc <= avg_calc;
         // Intermediate may wrap; the subtraction restores the exact in-range total.
         if (accept) begin
            sum         <= sum + SUM_W'(sample_data) - SUM_W'(evicted);
            fill_cnt    <= fill_next;
            window_full <= full_next;
         end
      end
   end

endmodule

// File: tb/tb_adc_moving_averager.sv
// tb/tb_adc_moving_averager.sv - randomized self-checking bench for adc_moving_averager
module tb_adc_moving_averager;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = '0;
   logic        flush = 1'b0;
   logic [15:0] averaged_adc;
   logic        avg_valid;
   logic        window_full;

   int tests = 0;
   int fails = 0;

   logic [15:0] q[$];
   logic        pend_v = 1'b0;
   logic [15:0] pend_val = '0;
   logic        exp_v = 1'b0;
   logic [15:0] exp_avg = '0;
   logic        exp_full = 1'b0;

   adc_moving_averager dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .flush        (flush),
      .averaged_adc (averaged_adc),
      .avg_valid    (avg_valid),
      .window_full  (window_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model_avg();
      longint s = 0;
      foreach (q[i]) s += q[i];
`ifdef ADC_AVG_ROUND_EN
      s = (s + DEPTH / 2) / DEPTH;
      if (s > 65535) s = 65535;
`else
      s = s / DEPTH;
`endif
      return 16'(s);
   endfunction

   task automatic cyc(input logic v, input logic [15:0] d, input logic f, input logic r);
      @(negedge clk);
      sample_valid = v;
      sample_data  = d;
      flush        = f;
      reset        = r;
      @(posedge clk);
      if (r) begin
         q.delete();
         pend_v  = 1'b0;
         exp_v   = 1'b0;
         exp_avg = '0;
      end else if (f) begin
         q.delete();
         pend_v = 1'b0;
         exp_v  = 1'b0;
      end else begin
         exp_v = pend_v;
         if (pend_v) exp_avg = pend_val;
         pend_v = 1'b0;
         if (v) begin
            q.push_back(d);
            if (q.size() > DEPTH) void'(q.pop_front());
            if (q.size() == DEPTH) begin
               pend_v   = 1'b1;
               pend_val = model_avg();
            end
         end
      end
      exp_full = (q.size() == DEPTH);
      #1;
   endtask

   task automatic test_reset();
      cyc(0, 16'h0, 0, 1);
      cyc(0, 16'h0, 0, 1);
      tests++; if (averaged_adc !== 16'h0) begin fails++; $display("FAIL reset_avg: got %h want 0000", averaged_adc); end
      tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", avg_valid); end
      tests++; if (window_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", window_full); end
      cyc(0, 16'h0, 0, 0);
   endtask

   task automatic test_warmup();
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 16'h8000, 0, 0);
         cyc(0, 16'h0, 0, 0);
         if (i < DEPTH) begin
            tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL warmup_valid[%0d]: got %b want 0", i, avg_valid); end
         end
      end
      tests++; if (avg_valid !== 1'b1) begin fails++; $display("FAIL warmup_pulse: got %b want 1", avg_valid); end
      tests++; if (averaged_adc !== 16'h8000) begin fails++; $display("FAIL warmup_avg: got %h want 8000", averaged_adc); end
      tests++; if (window_full !== 1'b1) begin fails++; $display("FAIL warmup_full: got %b want 1", window_full); end
      cyc(0, 16'h0, 0, 0);
      tests++; if (avg_valid !== 1'b0 || averaged_adc !== 16'h8000) begin fails++; $display("FAIL warmup_hold: got v=%b avg=%h want v=0 avg=8000", avg_valid, averaged_adc); end
   endtask

   task automatic test_step();
      logic [15:0] want;
      for (int i = 0; i < DEPTH; i++) cyc(1, 16'h1000, 0, 0);
      cyc(0, 16'h0, 0, 0);
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 16'h2000, 0, 0);
         cyc(0, 16'h0, 0, 0);
         want = 16'h1000 + 16'(i * 16'h0100);
         tests++; if (avg_valid !== 1'b1 || averaged_adc !== want) begin fails++; $display("FAIL step[%0d]: got v=%b avg=%h want v=1 avg=%h", i, avg_valid, averaged_adc, want); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got[$];
      int first_pulse;
      cyc(0, 16'h0, 0, 1);
      first_pulse = -1;
      for (int i = 0; i < 34; i++) begin
         if (i < 32) cyc(1, 16'(i), 0, 0);
         else cyc(0, 16'h0, 0, 0);
         if (avg_valid === 1'b1) begin
            if (first_pulse < 0) first_pulse = i;
            got.push_back(averaged_adc);
         end
      end
      tests++; if (first_pulse != 16) begin fails++; $display("FAIL b2b_first_cycle: got %0d want 16", first_pulse); end
      tests++; if (got.size() != 17) begin fails++; $display("FAIL b2b_count: got %0d want 17", got.size()); end
      for (int i = 0; i < got.size() && i < 17; i++) begin
`ifdef ADC_AVG_ROUND_EN
         tests++; if (got[i] !== 16'(8 + i)) begin fails++; $display("FAIL b2b_val[%0d]: got %0d want %0d", i, got[i], 8 + i); end
`else
         tests++; if (got[i] !== 16'(7 + i)) begin fails++; $display("FAIL b2b_val[%0d]: got %0d want %0d", i, got[i], 7 + i); end
`endif
      end
   endtask

   task automatic test_round();
      cyc(0, 16'h0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, (i < 8) ? 16'h0001 : 16'h0000, 0, 0);
      cyc(0, 16'h0, 0, 0);
`ifdef ADC_AVG_ROUND_EN
      tests++; if (averaged_adc !== 16'h0001) begin fails++; $display("FAIL round_half: got %h want 0001", averaged_adc); end
`else
      tests++; if (averaged_adc !== 16'h0000) begin fails++; $display("FAIL round_half: got %h want 0000", averaged_adc); end
`endif
      for (int i = 0; i < DEPTH; i++) cyc(1, 16'hFFFF, 0, 0);
      cyc(0, 16'h0, 0, 0);
      tests++; if (averaged_adc !== 16'hFFFF || avg_valid !== 1'b1) begin fails++; $display("FAIL round_max: got v=%b avg=%h want v=1 avg=ffff", avg_valid, averaged_adc); end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 9; i++) begin
         cyc(1, 16'($urandom), 0, 0);
         cyc(0, 16'h0, 0, 0);
         tests++; if (averaged_adc !== exp_avg) begin fails++; $display("FAIL flush_pre[%0d]: got %h want %h", i, averaged_adc, exp_avg); end
      end
      cyc(1, 16'h1234, 1, 0);
      tests++; if (window_full !== 1'b0) begin fails++; $display("FAIL flush_full: got %b want 0", window_full); end
      tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", avg_valid); end
      tests++; if (averaged_adc !== exp_avg) begin fails++; $display("FAIL flush_hold: got %h want %h", averaged_adc, exp_avg); end
      cyc(0, 16'h0, 0, 0);
      tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL flush_after: got %b want 0", avg_valid); end
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 16'h0400, 0, 0);
         cyc(0, 16'h0, 0, 0);
         if (i < DEPTH) begin
            tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL flush_warm[%0d]: got %b want 0", i, avg_valid); end
         end
      end
      tests++; if (avg_valid !== 1'b1 || averaged_adc !== 16'h0400) begin fails++; $display("FAIL flush_first: got v=%b avg=%h want v=1 avg=0400", avg_valid, averaged_adc); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20; i++) cyc(1, 16'($urandom), 0, 0);
      cyc(1, 16'hABCD, 0, 1);
      tests++; if (averaged_adc !== 16'h0 || avg_valid !== 1'b0 || window_full !== 1'b0) begin fails++; $display("FAIL rstmid_outs: got avg=%h v=%b full=%b want 0/0/0", averaged_adc, avg_valid, window_full); end
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 16'($urandom), 0, 0);
         tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL rstmid_warm[%0d]: got %b want 0", i, avg_valid); end
      end
      cyc(0, 16'h0, 0, 0);
      tests++; if (avg_valid !== 1'b1 || averaged_adc !== model_avg()) begin fails++; $display("FAIL rstmid_first: got v=%b avg=%h want v=1 avg=%h", avg_valid, averaged_adc, model_avg()); end
   endtask

   task automatic test_random();
      logic v, f, r;
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 99) < 60);
         f = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 99) < 1);
         cyc(v, 16'($urandom), f, r);
         tests++; if (avg_valid !== exp_v) begin fails++; $display("FAIL rand_valid[%0d]: got %b want %b", i, avg_valid, exp_v); end
         tests++; if (averaged_adc !== exp_avg) begin fails++; $display("FAIL rand_avg[%0d]: got %h want %h", i, averaged_adc, exp_avg); end
         tests++; if (window_full !== exp_full) begin fails++; $display("FAIL rand_full[%0d]: got %b want %b", i, window_full, exp_full); end
      end
      cyc(0, 16'h0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_step();
      test_back_to_back();
      test_round();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
